// File: rtl/dmem_burst_if.sv
// Command, write-data and read-data channels between a burst initiator client
// and dmem_burst_ctrl; master is the client side, slave is the controller.
interface dmem_burst_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 128
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/dmem_burst_ctrl.sv
// Burst initiator for one port of an SRAM2RW16x32-based data memory: streams
// write bursts into the SRAM and returns read bursts through a 2-entry buffer.
module dmem_burst_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  dmem_burst_if.slave       bus,
  output logic              busy,
  output logic              done,
  output logic              mem_csb,
  output logic              mem_web,
  output logic              mem_oeb,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_i,
  input  logic [DATA_W-1:0] mem_o
);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, len, beat;
  logic              inflight, done_q;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wptr, rptr;
  logic [1:0]        fifo_cnt;

  logic              cmd_fire, wr_fire, issue, finish;
  logic              push, pop, last;
  logic [2:0]        occ;

  assign last = (beat == len);
  assign push = inflight;
  assign pop  = bus.rd_valid & bus.rd_ready;
  // Words owned after this cycle's pop; one more issue is allowed while below 2.
  assign occ  = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    cmd_fire      = 1'b0;
    wr_fire       = 1'b0;
    issue         = 1'b0;
    finish        = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          bus.cmd_ready = 1'b1;
          cmd_fire      = bus.cmd_valid;
          if (bus.cmd_valid) state_nxt = bus.cmd_write ? WR : RD;
        end
        WR: begin
          bus.wr_ready = 1'b1;
          wr_fire      = bus.wr_valid;
          if (bus.wr_valid && last) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end
        end
        RD: begin
          issue = (occ < 3'd2);
          if (issue && last) state_nxt = DRAIN;
        end
        DRAIN: begin
          if (!inflight && (fifo_cnt - {1'b0, pop}) == 2'd0) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign mem_csb     = ~(wr_fire | issue);
  assign mem_web     = ~wr_fire;
  assign mem_oeb     = ~(inflight & ~rst);
  assign mem_a       = addr;
  assign mem_i       = bus.wr_data;
  assign busy        = (state != IDLE) & ~rst;
  assign done        = done_q & ~rst;
  assign bus.rd_valid = (fifo_cnt != 2'd0) & ~rst;
  assign bus.rd_data  = fifo_mem[rptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      len      <= '0;
      beat     <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      done_q   <= finish;
      inflight <= issue;
      if (cmd_fire) begin
        addr <= bus.cmd_addr;
        len  <= bus.cmd_len;
        beat <= '0;
      end else if (wr_fire || issue) begin
        addr <= addr + ADDR_W'(1);
        beat <= beat + ADDR_W'(1);
      end
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

  // NOTE: buffer storage has no reset; fifo_cnt alone decides what is valid,
  // so clearing the data words would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wptr] <= mem_o;
  end

endmodule

// File: tb/tb_dmem_burst_ctrl.sv
// Directed bench for dmem_burst_ctrl with a behavioural 16-word SRAM port model.
module tb_dmem_burst_ctrl;

  logic         clk;
  logic         rst;
  logic         busy, done;
  logic         mem_csb, mem_web, mem_oeb;
  logic [3:0]   mem_a;
  logic [127:0] mem_i, mem_o;

  logic [127:0] sram    [16];
  logic [127:0] exp_mem [16];

  int passed   = 0;
  int total    = 0;
  int done_cnt = 0;

  dmem_burst_if #(.ADDR_W(4), .DATA_W(128)) bus ();

  dmem_burst_ctrl #(.ADDR_W(4), .DATA_W(128)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .mem_csb (mem_csb),
    .mem_web (mem_web),
    .mem_oeb (mem_oeb),
    .mem_a   (mem_a),
    .mem_i   (mem_i),
    .mem_o   (mem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM port: write at the edge, read data appears in the cycle after the read edge.
  always @(posedge clk) begin
    if (!mem_csb && !mem_web) sram[mem_a] <= mem_i;
    if (!mem_csb &&  mem_web) mem_o <= sram[mem_a];
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [127:0] word(input int n);
    return {32'hC0DE0000 + 32'(n), 32'hBEEF0000 + 32'(n), ~(32'(n)), 32'(n * 3)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_cmd(input logic w, input logic [3:0] a, input logic [3:0] l);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    #2 check("cmd_ready_idle", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // stall bit n set -> wr_valid low in the n-th cycle after the command edge
  task automatic wr_burst(input logic [3:0] a, input logic [3:0] l, input logic [15:0] stall,
                          input int base);
    int beat = 0;
    int cyc  = 0;
    logic [3:0] ea;
    do_cmd(1'b1, a, l);
    while (beat <= int'(l) && cyc < 32) begin
      bus.wr_valid = (cyc < 16) ? ~stall[cyc] : 1'b1;
      bus.wr_data  = word(base + beat);
      #2;
      if (cyc == 0) begin
        check("wr_busy", busy, 1'b1);
        check("wr_cmd_ready_busy", bus.cmd_ready, 1'b0);
      end
      check("wr_ready", bus.wr_ready, 1'b1);
      if (bus.wr_valid) begin
        ea = a + 4'(beat);
        check("wr_csb", mem_csb, 1'b0);
        check("wr_web", mem_web, 1'b0);
        check("wr_addr", mem_a, ea);
        check("wr_mem_i", mem_i, word(base + beat));
        exp_mem[ea] = word(base + beat);
        beat++;
      end else begin
        check("wr_stall_csb", mem_csb, 1'b1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.wr_valid = 1'b0;
    #2;
    check("wr_beats", beat, int'(l) + 1);
    check("wr_done", done, 1'b1);
    check("wr_done_busy", busy, 1'b0);
    check("wr_done_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk); #3;
    check("wr_done_pulse", done, 1'b0);
  endtask

  // stall bit n set -> rd_ready low in the n-th cycle after the command edge
  task automatic rd_burst(input logic [3:0] a, input logic [3:0] l, input logic [15:0] stall,
                          input logic full);
    int got    = 0;
    int issued = 0;
    int cyc    = 0;
    int d0;
    logic [3:0] ea;
    d0 = done_cnt;
    do_cmd(1'b0, a, l);
    while (got <= int'(l) && cyc < 48) begin
      bus.rd_ready = (cyc < 16) ? ~stall[cyc] : 1'b1;
      #2;
      if (cyc == 0) check("rd_busy", busy, 1'b1);
      if (full) begin
        check("rd_valid_timing", bus.rd_valid, (cyc >= 2 && cyc <= int'(l) + 2));
        check("rd_oeb_capture", mem_oeb, !(cyc >= 1 && cyc <= int'(l) + 1));
      end
      if (!mem_csb) begin
        ea = a + 4'(issued);
        check("rd_web", mem_web, 1'b1);
        check("rd_addr", mem_a, ea);
        issued++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        ea = a + 4'(got);
        check("rd_data", bus.rd_data, exp_mem[ea]);
        got++;
      end
      check("rd_outstanding", (issued - got) <= 2, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    bus.rd_ready = 1'b1;
    #2;
    check("rd_beats", got, int'(l) + 1);
    check("rd_issued", issued, int'(l) + 1);
    check("rd_done", done, 1'b1);
    check("rd_done_busy", busy, 1'b0);
    @(posedge clk); #3;
    check("rd_done_pulse", done, 1'b0);
    check("rd_done_count", done_cnt, d0 + 1);
  endtask

  initial begin
    int d0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #3;
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_wr_ready", bus.wr_ready, 1'b0);
    check("rst_rd_valid", bus.rd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_csb", mem_csb, 1'b1);
    check("rst_web", mem_web, 1'b1);
    check("rst_oeb", mem_oeb, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check("idle_cmd_ready", bus.cmd_ready, 1'b1);
    check("idle_busy", busy, 1'b0);

    bus.rd_ready = 1'b1;
    wr_burst(4'd2, 4'd3, 16'h0000, 0);
    rd_burst(4'd2, 4'd3, 16'h0000, 1'b1);

    wr_burst(4'd6, 4'd7, 16'h0000, 10);
    rd_burst(4'd6, 4'd7, 16'h00F8, 1'b0);

    wr_burst(4'd14, 4'd3, 16'h0000, 20);
    rd_burst(4'd14, 4'd3, 16'h0000, 1'b1);

    wr_burst(4'd8, 4'd3, 16'hAAAA, 30);
    rd_burst(4'd8, 4'd3, 16'h0000, 1'b1);

    // Reset in the third returned beat of an 8-beat read.
    d0 = done_cnt;
    bus.rd_ready = 1'b1;
    do_cmd(1'b0, 4'd2, 4'd7);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #1;
    check("mid_third_valid", bus.rd_valid, 1'b1);
    check("mid_third_data", bus.rd_data, exp_mem[4]);
    rst = 1'b1;
    #1;
    check("mid_rst_rd_valid", bus.rd_valid, 1'b0);
    check("mid_rst_csb", mem_csb, 1'b1);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(posedge clk); #3;
    check("post_rst_rd_valid", bus.rd_valid, 1'b0);
    check("post_rst_csb", mem_csb, 1'b1);
    check("post_rst_cmd_ready", bus.cmd_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check("rel_cmd_ready", bus.cmd_ready, 1'b1);
    check("rel_rd_valid", bus.rd_valid, 1'b0);
    check("rel_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    check("rst_no_done", done_cnt, d0);

    rd_burst(4'd9, 4'd0, 16'h0000, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
